// File: rtl/mem_trace_capture.sv
// Run-control and change-trace capture for the processor's to_mem bus.
// Optional MEM_TRACE_STOP_ON_FULL_EN: end the run when the buffer fills.
module mem_trace_capture #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 64,
  parameter int TS_W       = 20,
  parameter int MAX_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W-1:0]         to_mem,
  input  logic                      rd_en,
  output logic [TS_W+DATA_W-1:0]    rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] val;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] prev;
  logic [AW-1:0]     wptr, rptr;
  entry_t            mem [DEPTH];

  logic full, chg, wr, rd, last, fill, go;

  // Full is judged on the start-of-cycle count, so a same-cycle read never frees a slot.
  assign full = (count == CW'(DEPTH));
  assign chg  = (state == RUN) && (to_mem != prev);
  assign wr   = chg && !full;
  assign rd   = rd_en && (count != '0);
  assign last = (ts == TS_W'(MAX_CYCLES - 1));
  assign go   = start && (state != RUN);

`ifdef MEM_TRACE_STOP_ON_FULL_EN
  assign fill = wr && !rd && (count == CW'(DEPTH - 1));
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= '{ts: ts, val: to_mem};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ts       <= '0;
      prev     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= mem[rptr];
      if (go) begin
        state    <= RUN;
        busy     <= 1'b1;
        done     <= 1'b0;
        ts       <= '0;
        prev     <= to_mem;
        wptr     <= '0;
        rptr     <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr) wptr <= wptr + 1'b1;
        if (rd) rptr <= rptr + 1'b1;
        count <= count + CW'(wr) - CW'(rd);
        if (chg && full) overflow <= 1'b1;
        if (state == RUN) begin
          ts   <= ts + 1'b1;
          prev <= to_mem;
          if (last || fill) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_trace_capture.sv
// Directed bench for mem_trace_capture (DEPTH=4, MAX_CYCLES=100, TS_W=8).
module tb_mem_trace_capture;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int MAXC   = 100;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0]      to_mem = '0;
  logic [TS_W+DATA_W-1:0] rd_data, exp_e;
  logic                   rd_valid, overflow, busy, done;
  logic [$clog2(DEPTH):0] count;
  int vectors = 0, miscompares = 0;

  mem_trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .to_mem(to_mem), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    vectors++;
    if ({rd_data, rd_valid, count, overflow, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got %h want 0", {rd_data, rd_valid, count, overflow, busy, done});
    end
    step(); rst = 1'b0;
    to_mem = 16'h0000; pulse_start();
    to_mem = 16'h0005; step();
    to_mem = 16'h0006; step();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    exp_e = {8'd0, 16'h0005};
    vectors++;
    if (rd_data !== exp_e || busy !== 1'b1) begin
      miscompares++; $display("FAIL prereset_read got %h busy %b want %h busy 1", rd_data, busy, exp_e);
    end
    rst = 1'b1; #1;
    vectors++;
    if ({rd_data, rd_valid, count, overflow, busy, done} !== '0) begin
      miscompares++; $display("FAIL midrun_reset got %h want 0", {rd_data, rd_valid, count, overflow, busy, done});
    end
    step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin to_mem = 16'(i * 7 + 1); step(); end
    vectors++;
    if (count !== '0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_capture got count %0d busy %b want 0 0", count, busy);
    end
  endtask

  task automatic test_basic();
    to_mem = 16'h0000; pulse_start();
    for (int i = 0; i < 5; i++) step();
    to_mem = 16'h1234; step();
    for (int i = 0; i < 3; i++) step();
    to_mem = 16'hBEEF; step();
    vectors++;
    if (count !== 3'd2) begin
      miscompares++; $display("FAIL basic_count got %0d want 2", count);
    end
    for (int i = 0; i < 89; i++) step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_early_done got done %b busy %b want 0 1", done, busy);
    end
    step();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 3'd2) begin
      miscompares++; $display("FAIL basic_done got done %b busy %b count %0d want 1 0 2", done, busy, count);
    end
    rd_en = 1'b1; step();
    exp_e = {8'd5, 16'h1234};
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_e) begin
      miscompares++; $display("FAIL basic_read0 got %b %h want 1 %h", rd_valid, rd_data, exp_e);
    end
    step();
    exp_e = {8'd9, 16'hBEEF};
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_e) begin
      miscompares++; $display("FAIL basic_read1 got %b %h want 1 %h", rd_valid, rd_data, exp_e);
    end
    step(); rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0 || count !== '0) begin
      miscompares++; $display("FAIL basic_empty_read got valid %b count %0d want 0 0", rd_valid, count);
    end
  endtask

  task automatic test_overflow();
    to_mem = 16'h0000; pulse_start();
    for (int i = 0; i < 10; i++) begin
      to_mem = 16'(i + 1); step();
      if (i == 3) begin
        vectors++;
`ifdef MEM_TRACE_STOP_ON_FULL_EN
        if (done !== 1'b1) begin miscompares++; $display("FAIL stop_on_full got done %b want 1", done); end
`else
        if (done !== 1'b0) begin miscompares++; $display("FAIL no_stop_on_full got done %b want 0", done); end
`endif
      end
    end
    vectors++;
`ifdef MEM_TRACE_STOP_ON_FULL_EN
    if (count !== 3'd4 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL full_stop_state got count %0d ovf %b want 4 0", count, overflow);
    end
`else
    if (count !== 3'd4 || overflow !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL overflow_state got count %0d ovf %b busy %b want 4 1 1", count, overflow, busy);
    end
    for (int i = 0; i < 89; i++) step();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL overflow_early_done got %b want 0", done); end
    step();
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL overflow_run_len got done %b want 1", done); end
`endif
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_e = {TS_W'(i), DATA_W'(i + 1)};
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_e) begin
        miscompares++; $display("FAIL overflow_entry%0d got %b %h want 1 %h", i, rd_valid, rd_data, exp_e);
      end
    end
    rd_en = 1'b0; step();
  endtask

  task automatic test_concurrent_wrap();
    logic [TS_W+DATA_W-1:0] exp_q[$];
    to_mem = 16'h0000; pulse_start();
    to_mem = 16'h0011; step();
    to_mem = 16'h0012; step();
    to_mem = 16'h0013; step();
    rd_en = 1'b1; step();
    exp_e = {8'd0, 16'h0011};
    vectors++;
    if (rd_data !== exp_e || count !== 3'd2) begin
      miscompares++; $display("FAIL cc_read_only got %h count %0d want %h 2", rd_data, count, exp_e);
    end
    to_mem = 16'h0014; step();
    exp_e = {8'd1, 16'h0012};
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_e || count !== 3'd2) begin
      miscompares++; $display("FAIL cc_rw_nonfull got %b %h count %0d want 1 %h 2", rd_valid, rd_data, count, exp_e);
    end
    rd_en = 1'b0;
    to_mem = 16'h0015; step();
    to_mem = 16'h0016; step();
    vectors++;
    if (count !== 3'd4) begin miscompares++; $display("FAIL cc_fill got %0d want 4", count); end
`ifdef MEM_TRACE_STOP_ON_FULL_EN
    exp_q = '{{8'd2, 16'h0013}, {8'd4, 16'h0014}, {8'd5, 16'h0015}, {8'd6, 16'h0016}};
`else
    to_mem = 16'h0017; rd_en = 1'b1; step(); rd_en = 1'b0;
    exp_e = {8'd2, 16'h0013};
    vectors++;
    if (rd_data !== exp_e || count !== 3'd3 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL cc_write_full_read got %h count %0d ovf %b want %h 3 1", rd_data, count, overflow, exp_e);
    end
    exp_q = '{{8'd4, 16'h0014}, {8'd5, 16'h0015}, {8'd6, 16'h0016}};
`endif
    rd_en = 1'b1;
    foreach (exp_q[i]) begin
      step();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin
        miscompares++; $display("FAIL cc_drain%0d got %b %h want 1 %h", i, rd_valid, rd_data, exp_q[i]);
      end
    end
    step(); rd_en = 1'b0;
    vectors++;
    if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL cc_empty_read got %b want 0", rd_valid); end
    for (int i = 0; i < 200 && done !== 1'b1; i++) step();
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL cc_done_timeout got done %b want 1", done); end
`ifndef MEM_TRACE_STOP_ON_FULL_EN
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL cc_overflow_sticky got %b want 1", overflow); end
`endif
  endtask

  task automatic test_restart();
    to_mem = 16'h0000; pulse_start();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL rs_restart1 got busy %b done %b count %0d ovf %b want 1 0 0 0", busy, done, count, overflow);
    end
    to_mem = 16'h0021; step();
    to_mem = 16'h0022; step();
    to_mem = 16'h0023; step();
    for (int i = 0; i < 8; i++) step();
    start = 1'b1; step(); start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || count !== 3'd3) begin
      miscompares++; $display("FAIL rs_start_in_run got busy %b count %0d want 1 3", busy, count);
    end
    for (int i = 0; i < 87; i++) step();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL rs_early_done got %b want 0", done); end
    step();
    vectors++;
    if (done !== 1'b1 || count !== 3'd3) begin
      miscompares++; $display("FAIL rs_done got done %b count %0d want 1 3", done, count);
    end
    to_mem = 16'h0030; pulse_start();
    vectors++;
    if (count !== '0 || overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL rs_restart2 got count %0d ovf %b busy %b done %b want 0 0 1 0", count, overflow, busy, done);
    end
    to_mem = 16'h0031; step();
    rd_en = 1'b1; step(); rd_en = 1'b0;
    exp_e = {8'd0, 16'h0031};
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== exp_e) begin
      miscompares++; $display("FAIL rs_ts_zero got %b %h want 1 %h", rd_valid, rd_data, exp_e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_concurrent_wrap();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_trace_capture.md
# mem_trace_capture

Cycle-accurate capture and run-control block that sits beside `processor` on the simulation/FPGA harness. It watches the processor's `to_mem` bus and stores every value change with a timestamp in a parametrised trace buffer. A built-in cycle watchdog ends the run after a fixed number of cycles. After the run, the trace is drained through a simple read handshake. It replaces hard-coded run-length delays with a reusable, depth- and width-configurable unit.

## Interface
- `DATA_W`, 16, width of the monitored `to_mem` bus
- `DEPTH`, 64, trace entries; power of two, ≥ 2
- `TS_W`, 20, timestamp width; must satisfy 2^TS_W > MAX_CYCLES
- `MAX_CYCLES`, 50000, run length in clocks (1 ms at the 20 ns clock)

- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a run; sampled in IDLE or DONE
- `to_mem`  in  DATA_W  monitored processor output
- `rd_en`  in  1  pop one trace entry
- `rd_data`  out  TS_W+DATA_W  popped entry, {timestamp, value}
- `rd_valid`  out  1  `rd_data` valid this cycle
- `count`  out  $clog2(DEPTH)+1  entries currently stored
- `overflow`  out  1  sticky: a change was dropped because the buffer was full
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE

## Operation
- FSM states: IDLE → RUN on `start`; RUN → DONE when `ts == MAX_CYCLES-1`; DONE → RUN on `start`. `start` in RUN is ignored.
- Entering RUN:
  - `ts` ← 0; `prev` ← `to_mem`.
  - Buffer pointers and `count` are cleared; `overflow` ← 0.
- In RUN, every cycle:
  - `ts` increments.
  - If `to_mem != prev`: write `{ts, to_mem}` when `count < DEPTH`, otherwise set `overflow`.
  - `prev` ← `to_mem`.
- The entry timestamp is the `ts` value before the increment. The first RUN cycle has `ts = 0`.
- Buffer is a circular FIFO. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Read handshake:
  - `rd_en` with `count > 0` pops the oldest entry.
  - `rd_en` with `count = 0` is ignored; `rd_valid` stays low.
  - Reads are legal in any state.
- Simultaneous read and write:
  - The full check uses `count` at the start of the cycle. A write while full is dropped even if a read occurs in the same cycle.
  - Otherwise both happen and `count` is unchanged.
- No capture occurs in IDLE or DONE.

## Timing
- Reset values: `rd_data` = 0, `rd_valid` = 0, `count` = 0, `overflow` = 0, `busy` = 0, `done` = 0. State is IDLE; `ts`, `prev` and pointers are 0.
- Start latency:
  - `start` at edge N → `busy` = 1 after edge N.
  - The first compare happens at edge N+1 against the `to_mem` value latched at N.
- Capture latency: a change presented before edge K is written at edge K. `count` reflects it after edge K.
- Read latency: `rd_en` at edge K → `rd_data`/`rd_valid` registered after edge K, for one cycle.
- Run end: `done` rises after the edge on which `ts = MAX_CYCLES-1` is processed. That final cycle's change is still captured. Exactly MAX_CYCLES compare cycles occur per run.
- `rst` mid-run: all state returns to reset values immediately. Buffered entries are lost.

## Configuration
- `MEM_TRACE_STOP_ON_FULL_EN`
  - Defined: the write that makes `count == DEPTH` also forces RUN → DONE on that edge, regardless of `ts`. `overflow` can never assert.
  - Undefined: the run always lasts MAX_CYCLES; excess changes set `overflow`.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` mid-run; toggle `to_mem` in IDLE.
  - Required: all outputs 0 after reset; `count` stays 0 in IDLE.
- Basic capture (MAX_CYCLES=100):
  - Stimulus: `start`; `to_mem` 0x0000 → 0x1234 at ts 5 → 0xBEEF at ts 9; run to DONE, then drain.
  - Required: `count` = 2. Reads return {5, 0x1234} then {9, 0xBEEF}. `done` = 1 exactly 100 cycles after `start`.
- Overflow (DEPTH=4, macro undefined):
  - Stimulus: change `to_mem` every cycle for 10 cycles.
  - Required: `count` = 4; `overflow` = 1. Entries hold ts 0–3; run continues to MAX_CYCLES.
- Stop-on-full (DEPTH=4, macro defined):
  - Same stimulus as Overflow.
  - Required: `done` = 1 after the 4th write; `overflow` = 0.
- Concurrent read/write and wrap:
  - Stimulus: DEPTH=4; 6 changes interleaved with reads at full and at non-full.
  - Required: pointers wrap; FIFO order is preserved; a write while full is dropped even with `rd_en` in the same cycle; `rd_en` on empty gives `rd_valid` = 0.
- Restart:
  - Stimulus: `start` in DONE with 3 entries left unread.
  - Required: `count` = 0, `overflow` = 0, `ts` restarts at 0; `start` pulses during RUN have no effect.
